// File: rtl/chi_tx_lcrd_chn.sv
// CHI link-layer TX channel stage: L-credit tracking, FLITPEND/FLITV pipeline, deactivation handling.
// Optional CHI_TX_LCRD_RETURN_EN: on deactivation, hand back held credits as all-zero LCrdReturn flits.
module chi_tx_lcrd_chn #(
    parameter int FLIT_WIDTH = 128,
    parameter int MAX_CRD    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  link_up,
    input  logic                  link_deact,
    input  logic                  in_flit_valid,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    output logic                  in_flit_ready,
    input  logic                  CHI_TXLCRDV,
    output logic                  CHI_TXFLITPEND,
    output logic                  CHI_TXFLITV,
    output logic [FLIT_WIDTH-1:0] CHI_TXFLIT,
    output logic [3:0]            crd_cnt,
    output logic                  crd_returned,
    output logic                  crd_ovf
);

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RETURN = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_CRD);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [3:0]            crd_cnt_r;
    logic                  p_valid_r;
    logic                  p_lcrd_r;
    logic [FLIT_WIDTH-1:0] p_flit_r;
    logic                  v_valid_r;
    logic [FLIT_WIDTH-1:0] v_flit_r;
    logic                  crd_returned_r;
    logic                  crd_ovf_r;
    logic                  ready_s;
    logic                  accept_s;
    logic                  ret_issue_s;
    logic                  crd_inc_s;
    logic                  crd_dec_s;
    logic                  pipe_empty_s;
    logic                  done_s;

    // Handshake, credit events and deactivation-complete condition
    always_comb begin
        ready_s      = (state_r == ST_RUN) && (crd_cnt_r != 4'd0);
        accept_s     = in_flit_valid && ready_s;
        pipe_empty_s = !p_valid_r && !v_valid_r;
`ifdef CHI_TX_LCRD_RETURN_EN
        // A bridge flit left in stage P must move on before return flits start
        ret_issue_s  = (state_r == ST_RETURN) && (crd_cnt_r != 4'd0) && !(p_valid_r && !p_lcrd_r);
        crd_inc_s    = CHI_TXLCRDV && ((state_r == ST_RUN) || (state_r == ST_RETURN));
        // A credit landing in the final cycle still has to be returned, so hold off
        done_s       = (state_r == ST_RETURN) && (crd_cnt_r == 4'd0) && pipe_empty_s && !CHI_TXLCRDV;
`else
        ret_issue_s  = 1'b0;
        crd_inc_s    = CHI_TXLCRDV && (state_r == ST_RUN);
        done_s       = (state_r == ST_RETURN) && pipe_empty_s;
`endif
        crd_dec_s    = accept_s || ret_issue_s;
    end

    // Link state next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_STOP: begin
                if (link_up) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_RUN: begin
                if (link_deact) begin
                    state_nxt_s = ST_RETURN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RETURN: begin
                if (done_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_RETURN;
                end
            end
            default: state_nxt_s = ST_STOP;
        endcase
    end

    // State register and completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_STOP;
            crd_returned_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            crd_returned_r <= done_s;
        end
    end

    // Credit counter with saturation and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            crd_cnt_r <= 4'd0;
            crd_ovf_r <= 1'b0;
        end else if (done_s) begin
            crd_cnt_r <= 4'd0;
        end else if (crd_inc_s && !crd_dec_s) begin
            if (crd_cnt_r == MAX_CNT) begin
                crd_ovf_r <= 1'b1;
            end else begin
                crd_cnt_r <= crd_cnt_r + 4'd1;
            end
        end else if (crd_dec_s && !crd_inc_s) begin
            crd_cnt_r <= crd_cnt_r - 4'd1;
        end
    end

    // Two-stage output pipeline; no backpressure since credit is taken at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid_r <= 1'b0;
            p_lcrd_r  <= 1'b0;
            p_flit_r  <= {FLIT_WIDTH{1'b0}};
            v_valid_r <= 1'b0;
            v_flit_r  <= {FLIT_WIDTH{1'b0}};
        end else begin
            p_valid_r <= accept_s || ret_issue_s;
            p_lcrd_r  <= ret_issue_s;
            if (accept_s) begin
                p_flit_r <= in_flit;
            end else if (ret_issue_s) begin
                p_flit_r <= {FLIT_WIDTH{1'b0}};
            end
            v_valid_r <= p_valid_r;
            if (p_valid_r) begin
                v_flit_r <= p_flit_r;
            end
        end
    end

    assign in_flit_ready  = ready_s;
    assign CHI_TXFLITPEND = p_valid_r;
    assign CHI_TXFLITV    = v_valid_r;
    assign CHI_TXFLIT     = v_flit_r;
    assign crd_cnt        = crd_cnt_r;
    assign crd_returned   = crd_returned_r;
    assign crd_ovf        = crd_ovf_r;

endmodule

// File: tb/tb_chi_tx_lcrd_chn.sv
// Scoreboard bench for chi_tx_lcrd_chn: directed stimulus pushes expected flits, a monitor checks the pins.
module tb_chi_tx_lcrd_chn;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         link_up = 1'b0;
    logic         link_deact = 1'b0;
    logic         in_flit_valid = 1'b0;
    logic [W-1:0] in_flit = {W{1'b0}};
    logic         in_flit_ready;
    logic         CHI_TXLCRDV = 1'b0;
    logic         CHI_TXFLITPEND;
    logic         CHI_TXFLITV;
    logic [W-1:0] CHI_TXFLIT;
    logic [3:0]   crd_cnt;
    logic         crd_returned;
    logic         crd_ovf;

    int           vecs = 0;
    int           errs = 0;
    logic [W-1:0] exp_q[$];
    logic         prev_pend = 1'b0;
    int           pulses;

    chi_tx_lcrd_chn #(.FLIT_WIDTH(W), .MAX_CRD(15)) dut (
        .clk(clk), .reset(reset), .link_up(link_up), .link_deact(link_deact),
        .in_flit_valid(in_flit_valid), .in_flit(in_flit), .in_flit_ready(in_flit_ready),
        .CHI_TXLCRDV(CHI_TXLCRDV), .CHI_TXFLITPEND(CHI_TXFLITPEND), .CHI_TXFLITV(CHI_TXFLITV),
        .CHI_TXFLIT(CHI_TXFLIT), .crd_cnt(crd_cnt), .crd_returned(crd_returned), .crd_ovf(crd_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [31:0] k);
        return {4{k}};
    endfunction

    // Monitor: every valid flit must match the scoreboard head and follow a PEND cycle
    always @(negedge clk) begin
        if (CHI_TXFLITV) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_flitv", 128'd1, 128'd0);
            end else begin
                chk("flit_data", CHI_TXFLIT, exp_q.pop_front());
                chk("pend_before_v", {127'd0, prev_pend}, 128'd1);
            end
        end
        prev_pend = CHI_TXFLITPEND;
    end

    initial begin
        step(2);
        reset = 1'b0;
        chk("rst_cnt", 128'(crd_cnt), 128'd0);
        chk("rst_ready", 128'(in_flit_ready), 128'd0);
        chk("rst_pend", 128'(CHI_TXFLITPEND), 128'd0);
        chk("rst_flitv", 128'(CHI_TXFLITV), 128'd0);
        chk("rst_flit", CHI_TXFLIT, 128'd0);
        chk("rst_ovf", 128'(crd_ovf), 128'd0);
        chk("rst_returned", 128'(crd_returned), 128'd0);

        // Credit-limited send
        link_up = 1'b1;
        step(1);
        chk("run_nocrd_ready", 128'(in_flit_ready), 128'd0);
        CHI_TXLCRDV = 1'b1;
        step(3);
        CHI_TXLCRDV = 1'b0;
        chk("cnt3", 128'(crd_cnt), 128'd3);
        chk("ready_with_crd", 128'(in_flit_ready), 128'd1);
        in_flit_valid = 1'b1;
        in_flit = mk(32'hA); exp_q.push_back(mk(32'hA)); step(1);
        chk("lat_pend", 128'(CHI_TXFLITPEND), 128'd1);
        chk("lat_novalid", 128'(CHI_TXFLITV), 128'd0);
        in_flit = mk(32'hB); exp_q.push_back(mk(32'hB)); step(1);
        chk("lat_valid", 128'(CHI_TXFLITV), 128'd1);
        in_flit = mk(32'hC); exp_q.push_back(mk(32'hC)); step(1);
        in_flit = mk(32'hD);
        chk("out_of_crd_ready", 128'(in_flit_ready), 128'd0);
        chk("out_of_crd_cnt", 128'(crd_cnt), 128'd0);
        chk("b2b_pend", 128'(CHI_TXFLITPEND), 128'd1);
        step(3);
        CHI_TXLCRDV = 1'b1;
        chk("no_bypass_ready", 128'(in_flit_ready), 128'd0);
        step(1);
        CHI_TXLCRDV = 1'b0;
        chk("grant4_ready", 128'(in_flit_ready), 128'd1);
        exp_q.push_back(mk(32'hD));
        step(1);
        in_flit = mk(32'hE);
        chk("after_d_ready", 128'(in_flit_ready), 128'd0);
        in_flit_valid = 1'b0;
        step(4);
        chk("drain1_q", 128'(exp_q.size()), 128'd0);

        // Simultaneous grant and accept
        CHI_TXLCRDV = 1'b1;
        step(2);
        chk("cnt2", 128'(crd_cnt), 128'd2);
        in_flit_valid = 1'b1;
        in_flit = mk(32'hF); exp_q.push_back(mk(32'hF));
        step(1);
        CHI_TXLCRDV = 1'b0;
        in_flit_valid = 1'b0;
        chk("sim_inc_dec_cnt", 128'(crd_cnt), 128'd2);
        step(4);

        // Deactivate holding 4 credits, one more credit granted during RETURN
        CHI_TXLCRDV = 1'b1;
        step(2);
        CHI_TXLCRDV = 1'b0;
        chk("cnt4", 128'(crd_cnt), 128'd4);
        link_deact = 1'b1;
        link_up = 1'b0;
        step(1);
        link_deact = 1'b0;
`ifdef CHI_TX_LCRD_RETURN_EN
        for (int i = 0; i < 5; i++) exp_q.push_back(128'd0);
`endif
        CHI_TXLCRDV = 1'b1;
        pulses = 0;
        step(1);
        CHI_TXLCRDV = 1'b0;
`ifndef CHI_TX_LCRD_RETURN_EN
        chk("noret_cnt_cleared", 128'(crd_cnt), 128'd0);
`endif
        if (crd_returned) pulses++;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (crd_returned) pulses++;
        end
        chk("returned_pulses", 128'(pulses), 128'd1);
        chk("deact_cnt", 128'(crd_cnt), 128'd0);
        chk("deact_q", 128'(exp_q.size()), 128'd0);
        CHI_TXLCRDV = 1'b1;
        step(2);
        CHI_TXLCRDV = 1'b0;
        chk("stop_ignores_crd", 128'(crd_cnt), 128'd0);
        chk("stop_ready", 128'(in_flit_ready), 128'd0);

        // Overflow
        link_up = 1'b1;
        step(1);
        CHI_TXLCRDV = 1'b1;
        step(16);
        CHI_TXLCRDV = 1'b0;
        chk("ovf_cnt", 128'(crd_cnt), 128'd15);
        chk("ovf_flag", 128'(crd_ovf), 128'd1);
        step(3);
        chk("ovf_sticky", 128'(crd_ovf), 128'd1);

        // Reset mid-stream with two flits in flight
        in_flit_valid = 1'b1;
        in_flit = mk(32'h6); exp_q.push_back(mk(32'h6)); step(1);
        in_flit = mk(32'h7); step(1);
        in_flit_valid = 1'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_rst_pend", 128'(CHI_TXFLITPEND), 128'd0);
        chk("mid_rst_flitv", 128'(CHI_TXFLITV), 128'd0);
        chk("mid_rst_flit", CHI_TXFLIT, 128'd0);
        chk("mid_rst_cnt", 128'(crd_cnt), 128'd0);
        chk("mid_rst_ovf", 128'(crd_ovf), 128'd0);
        chk("mid_rst_ready", 128'(in_flit_ready), 128'd0);
        step(10);
        chk("final_q", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
